// File: rtl/c2h_src_arbiter_if.sv
// Source-to-writer bus for the C2H source arbiter.
// Carries the per-source request/data/taken signals and the writer-side
// package handshake, plus the id of the source owning the presented package.
//   master : arbiter side (drives src_taken, wr_data, wr_data_valid, grant_id)
//   slave  : environment side (drives src_valid, src_data, wr_data_next)
interface c2h_src_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 4072
);
  localparam int GW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_taken;
  logic [DATA_W-1:0]         wr_data;
  logic                      wr_data_valid;
  logic                      wr_data_next;
  logic [GW-1:0]             grant_id;

  modport master (
    input  src_valid, src_data, wr_data_next,
    output src_taken, wr_data, wr_data_valid, grant_id
  );

  modport slave (
    output src_valid, src_data, wr_data_next,
    input  src_taken, wr_data, wr_data_valid, grant_id
  );
endinterface

// File: rtl/c2h_src_arbiter.sv
// Round-robin scheduler sharing one C2H package writer among NUM_SRC sources.
// A package from the granted source is captured into a holding register,
// presented on wr_data/wr_data_valid until the writer pulses wr_data_next,
// and the grant is kept for up to BURST_PKTS packages. A writer that stalls
// for TIMEOUT cycles causes the package to be dropped and sets a sticky flag.
// Ports:
//   m_axis_c2h_aclk    clock
//   m_axis_c2h_aresetn asynchronous active-low reset
//   enable             0 = no new capture (a presented package still completes)
//   bus                source/writer bus (master modport)
//   busy               arbiter not idle
//   timeout_err        sticky writer-stall flag
//   pkt_count          delivered packages, wraps modulo 2^32
module c2h_src_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_W     = 4072,
  parameter int BURST_PKTS = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                     m_axis_c2h_aclk,
  input  logic                     m_axis_c2h_aresetn,
  input  logic                     enable,
  c2h_src_arbiter_if.master        bus,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [31:0]              pkt_count
);

  localparam int GW = $clog2(NUM_SRC);
  localparam int BW = $clog2(BURST_PKTS + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       last_q, last_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [BW-1:0]       burst_q, burst_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_SRC-1:0]  taken_q, taken_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [31:0]         cnt_q, cnt_d;

  logic                win_found;
  logic [GW-1:0]       win_idx;

  // Round-robin search starting just after the last granted source.
  always_comb begin
    int unsigned cand;
    logic [GW-1:0] idx;
    win_found = 1'b0;
    win_idx   = last_q;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = (32'(last_q) + k) % 32'(NUM_SRC);
      idx  = GW'(cand);
      if (!win_found && bus.src_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    burst_d = burst_q;
    timer_d = timer_q;
    data_d  = data_q;
    taken_d = '0;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (enable && win_found) begin
          data_d           = bus.src_data[win_idx*DATA_W +: DATA_W];
          grant_d          = win_idx;
          last_d           = win_idx;
          burst_d          = BW'(1);
          taken_d[win_idx] = 1'b1;
          valid_d          = 1'b1;
          timer_d          = '0;
          state_d          = PRESENT;
        end
      end
      PRESENT: begin
        // A consume pulse takes priority over an expiring timer.
        if (bus.wr_data_next) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 32'd1;
          if (burst_q < BW'(BURST_PKTS) && enable && bus.src_valid[grant_q]) begin
            data_d           = bus.src_data[grant_q*DATA_W +: DATA_W];
            taken_d[grant_q] = 1'b1;
            burst_d          = burst_q + BW'(1);
            state_d          = GAP;
          end else begin
            state_d = IDLE;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      GAP: begin
        valid_d = 1'b1;
        timer_d = '0;
        state_d = PRESENT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      state_q <= IDLE;
      last_q  <= GW'(NUM_SRC - 1);
      grant_q <= '0;
      burst_q <= '0;
      timer_q <= '0;
      data_q  <= '0;
      taken_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      taken_q <= taken_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.src_taken     = taken_q;
  assign bus.wr_data       = data_q;
  assign bus.wr_data_valid = valid_q;
  assign bus.grant_id      = grant_q;
  assign busy              = (state_q != IDLE);
  assign timeout_err       = err_q;
  assign pkt_count         = cnt_q;

endmodule

// File: tb/tb_c2h_src_arbiter.sv
// Bench for c2h_src_arbiter: randomized sources and writer checked every cycle
// against a package-level model, plus a few directed literal expectations.
module tb_c2h_src_arbiter;
  localparam int NS = 4;
  localparam int DW = 16;
  localparam int BP = 3;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic busy, timeout_err;
  logic [31:0] pkt_count;

  c2h_src_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW)) bus ();

  c2h_src_arbiter #(
    .NUM_SRC(NS), .DATA_W(DW), .BURST_PKTS(BP), .TIMEOUT(TO)
  ) dut (
    .m_axis_c2h_aclk(clk),
    .m_axis_c2h_aresetn(rst_n),
    .enable(enable),
    .bus(bus),
    .busy(busy),
    .timeout_err(timeout_err),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Package-level model: is a package on the bus, how long has it waited,
  // is a follow-on package waiting out its one-cycle gap, how many served.
  bit            m_valid, m_gap;
  int            m_age, m_served, m_last;
  int            m_grant;
  logic [DW-1:0] m_data;
  logic [NS-1:0] m_taken;
  int unsigned   m_count;
  bit            m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_gap = 0; m_age = 0; m_served = 0; m_last = NS - 1;
      m_grant = 0; m_data = '0; m_taken = '0; m_count = 0; m_err = 0;
    end else begin
      m_taken = '0;
      if (m_valid) begin
        if (bus.wr_data_next) begin
          m_count++;
          m_valid = 0;
          if (m_served < BP && enable && bus.src_valid[m_grant]) begin
            m_data = bus.src_data[m_grant*DW +: DW];
            m_taken[m_grant] = 1'b1;
            m_served++;
            m_gap = 1;
          end
        end else if (m_age + 1 == TO) begin
          m_err = 1;
          m_valid = 0;
        end else begin
          m_age++;
        end
      end else if (m_gap) begin
        m_gap = 0;
        m_valid = 1;
        m_age = 0;
      end else if (enable && |bus.src_valid) begin
        for (int k = 1; k <= NS; k++) begin
          int idx;
          idx = (m_last + k) % NS;
          if (!m_valid && bus.src_valid[idx]) begin
            m_valid = 1;
            m_grant = idx;
            m_last = idx;
            m_data = bus.src_data[idx*DW +: DW];
            m_taken[idx] = 1'b1;
            m_served = 1;
            m_age = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("wr_data_valid", bus.wr_data_valid, m_valid);
      check("src_taken", bus.src_taken, m_taken);
      check("src_taken_onehot0", $onehot0(bus.src_taken), 1);
      check("busy", busy, m_valid || m_gap);
      check("grant_id", bus.grant_id, m_grant);
      check("pkt_count", pkt_count, m_count);
      check("timeout_err", timeout_err, m_err);
      if (m_valid) check("wr_data", bus.wr_data, m_data);
    end
  end

  task automatic drive_idle();
    bus.src_valid = '0;
    bus.src_data = '0;
    bus.wr_data_next = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // mode 0: random writer, 1: never consumes, 2: consumes on final timeout cycle
  task automatic rand_phase(input int cycles, input int mode, input int density, input int en_pct);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk); #1;
      for (int s = 0; s < NS; s++)
        bus.src_valid[s] = ($urandom_range(0, 99) < density);
      for (int s = 0; s < NS; s++)
        bus.src_data[s*DW +: DW] = DW'($urandom);
      enable = ($urandom_range(0, 99) < en_pct);
      case (mode)
        0: bus.wr_data_next = m_valid ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
        1: bus.wr_data_next = 1'b0;
        default: bus.wr_data_next = m_valid && (m_age == TO - 1);
      endcase
    end
    @(negedge clk); #1;
    drive_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    chk_on = 1'b1;
    do_reset();

    // Directed: single package from source 0, consumed 5 cycles after valid.
    @(negedge clk);
    check("reset_pkt_count", pkt_count, 0);
    check("reset_wr_data", bus.wr_data, 0);
    #1;
    enable = 1'b1;
    bus.src_valid = 4'b0001;
    bus.src_data[0 +: DW] = 16'hA5C3;
    @(negedge clk);
    check("dir_valid", bus.wr_data_valid, 1);
    check("dir_data", bus.wr_data, 16'hA5C3);
    check("dir_taken", bus.src_taken, 4'b0001);
    check("dir_grant", bus.grant_id, 0);
    #1 bus.src_valid = '0;
    repeat (4) @(negedge clk);
    check("dir_hold_data", bus.wr_data, 16'hA5C3);
    #1 bus.wr_data_next = 1'b1;
    @(negedge clk);
    check("dir_count", pkt_count, 1);
    check("dir_idle", busy, 0);
    #1 bus.wr_data_next = 1'b0;

    // Random traffic, then the writer consuming exactly on the expiry cycle.
    rand_phase(600, 0, 70, 90);
    rand_phase(300, 0, 30, 60);
    do_reset();
    rand_phase(300, 2, 80, 100);
    @(negedge clk);
    check("coincident_no_err", timeout_err, 0);
    check("coincident_counted", pkt_count > 0, 1);

    // Reset while a package is presented.
    #1;
    enable = 1'b1;
    bus.src_valid = 4'b0110;
    begin
      int waited = 0;
      while (!m_valid && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      check("rst_wait_present", m_valid, 1);
    end
    #3 rst_n = 1'b0;
    #1;
    check("rst_valid", bus.wr_data_valid, 0);
    check("rst_taken", bus.src_taken, 0);
    check("rst_busy", busy, 0);
    @(negedge clk); #1;
    bus.src_valid = 4'b1111;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_first_grant", bus.grant_id, 0);
    check("rst_first_taken", bus.src_taken, 4'b0001);

    // Stalled writer: packages dropped, sticky error.
    rand_phase(200, 1, 80, 100);
    repeat (3) @(negedge clk);
    check("stall_err", timeout_err, 1);
    check("stall_no_count", pkt_count, 0);
    rand_phase(400, 0, 60, 90);
    @(negedge clk);
    check("err_sticky", timeout_err, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/c2h_src_arbiter.md
Name: c2h_src_arbiter

Overview:
- Round-robin scheduler that shares the single C2H AXI-Stream package writer among NUM_SRC wide-data producers.
- Captures one DATA_W-bit package from the granted source into a holding register.
- Presents the package to the writer on wr_data/wr_data_valid and waits for the writer's wr_data_next pulse before supplying the next package.
- Keeps a grant for up to BURST_PKTS packages, detects a stalled writer with a timeout, and counts delivered packages.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..16)
- DATA_W, 4072, package width in bits
- BURST_PKTS, 8, maximum packages served per grant before re-arbitration (1..255)
- TIMEOUT, 1024, cycles allowed in PRESENT without wr_data_next before abort (>=2)

Ports:
- m_axis_c2h_aclk  in  1  clock
- m_axis_c2h_aresetn  in  1  asynchronous active-low reset
- enable  in  1  0 = no new capture; a package already presented still completes
- src_valid  in  NUM_SRC  per-source package available
- src_data  in  NUM_SRC*DATA_W  source i occupies bits [i*DATA_W +: DATA_W]
- src_taken  out  NUM_SRC  one-cycle pulse: package of source i captured
- wr_data  out  DATA_W  package to writer
- wr_data_valid  out  1  wr_data valid and stable
- wr_data_next  in  1  one-cycle pulse from writer: current package consumed
- grant_id  out  clog2(NUM_SRC)  source owning current package
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky stall flag
- pkt_count  out  32  packages delivered, wraps modulo 2^32

Behaviour:
- Clock and reset: one clock, m_axis_c2h_aclk. Reset m_axis_c2h_aresetn is asynchronous and active-low.
- Reset values: all outputs 0 (wr_data = 0); state IDLE; last_grant = NUM_SRC-1, so source 0 has first priority; burst_cnt 0; timer 0.
- Reset asserted mid-operation: everything cleared at once; the held package is discarded; no src_taken is issued.
- FSM states: IDLE, PRESENT, GAP.
- IDLE:
  - Condition: enable=1 and |src_valid.
  - Winner w = first asserted src_valid searching last_grant+1, +2, … with wrap modulo NUM_SRC.
  - Registered actions: holding reg <= src_data[w]; grant_id <= w; last_grant <= w; burst_cnt <= 1; src_taken[w] <= 1 for one cycle; wr_data_valid <= 1; timer <= 0; go to PRESENT.
  - Latency: src_valid sampled high -> wr_data_valid high on the next cycle.
- PRESENT:
  - wr_data_valid=1 and wr_data held stable. src_valid changes are ignored.
  - timer increments each cycle.
  - On wr_data_next=1:
    - wr_data_valid <= 0; pkt_count++.
    - If burst_cnt < BURST_PKTS and enable and src_valid[grant_id]: capture from the same source, pulse src_taken[grant_id], burst_cnt++, go to GAP.
    - Otherwise: go to IDLE.
  - If timer reaches TIMEOUT-1 without wr_data_next:
    - timeout_err <= 1; wr_data_valid <= 0; package dropped (not counted); go to IDLE.
- GAP:
  - wr_data_valid=0 for exactly one cycle, then wr_data_valid <= 1, timer <= 0, go to PRESENT.
  - Within a burst, wr_data_valid is low exactly one cycle between packages.
- wr_data_next in IDLE or GAP: ignored.
- Same-cycle events:
  - wr_data_next and timer expiry together: wr_data_next wins (package counted, no error).
  - enable falling during PRESENT: current package completes; no further capture.
- timeout_err clears only on reset.
- src_taken: one-hot or zero at all times.

Test Plan:
- Reset then src_valid=4'b0001, data A; writer pulses next 5 cycles after valid -> wr_data_valid high cycle after capture, wr_data=A, src_taken=0001 one cycle, grant_id=0, pkt_count=1, back to IDLE.
- All four sources valid continuously, BURST_PKTS=1 -> grants in order 0,1,2,3,0; each src_taken pulses once per grant.
- Source 2 continuously valid, BURST_PKTS=8 -> 8 packages each separated by exactly one valid-low cycle; after the 8th, IDLE re-arbitrates and grants 2 again only if it is the sole requester.
- Writer never pulses next, TIMEOUT=16 -> wr_data_valid drops after 16 cycles of PRESENT, timeout_err=1 sticky, pkt_count unchanged.
- wr_data_next coincident with the final timeout cycle -> pkt_count increments, timeout_err stays 0.
- Reset pulled low during PRESENT -> wr_data_valid, src_taken and busy are 0 immediately; after release, source 0 has first priority.
